fsm_sync_multi: RTL and testbench

Parametrised, multi-channel successor to the single-channel RF-trigger/shift-enable state machine. Each channel:
- arms on its rfin request and goes ACTIVE;
- synchronises its asynchronous sh_en through a configurable-depth flop chain;
- returns to IDLE on the synchronised sh_en falling edge, on a programmable timeout, or on channel disable.
It sits between the RF front-end detectors and the shift-register capture logic, and provides per-channel completion and error status.

---
 rtl/fsm_sync_pkg.sv | 12 +
 rtl/sync_chain.sv | 25 ++
 rtl/fsm_sync_multi.sv | 102 ++++++++++
 tb/tb_fsm_sync_multi.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/fsm_sync_pkg.sv
// Shared definitions for the multi-channel RF-trigger / shift-enable FSM.
package fsm_sync_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } ch_state_e;

  localparam int unsigned MIN_SYNC_STAGES = 2;
  localparam int unsigned TIMEOUT_DISABLE = 0;

endpackage

// File: rtl/sync_chain.sv
// N-stage single-bit synchroniser with synchronous active-high reset.
module sync_chain
  import fsm_sync_pkg::*;
#(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  // Depths below the metastability minimum are clamped up.
  localparam int unsigned DEPTH = (STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : STAGES;

  logic [DEPTH-1:0] ff;

  always_ff @(posedge clk) begin
    if (rst) ff <= '0;
    else     ff <= {ff[DEPTH-2:0], d};
  end

  assign q = ff[DEPTH-1];

endmodule

// File: rtl/fsm_sync_multi.sv
// Multi-channel RF-trigger / shift-enable FSM with per-channel timeout.
// Define FSM_SYNC_RFIN_SYNC_EN to also synchronise rfin before the FSM.
module fsm_sync_multi
  import fsm_sync_pkg::*;
#(
  parameter int unsigned NCH         = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       ch_en,
  input  logic [NCH-1:0]       rfin,
  input  logic [NCH-1:0]       sh_en,
  input  logic [TIMEOUT_W-1:0] timeout_cycles,
  input  logic [NCH-1:0]       err_clr,
  output logic [NCH-1:0]       state,
  output logic [NCH-1:0]       sh_en_sync,
  output logic [NCH-1:0]       done_pulse,
  output logic [NCH-1:0]       timeout_err
);

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic                 sync_q;
    logic                 sh_prev;
    logic                 rfin_eff;
    logic                 fall;
    logic                 to_hit;
    logic                 done_q;
    logic                 err_q;
    logic [TIMEOUT_W-1:0] cnt;
    ch_state_e            st;

    sync_chain #(.STAGES(SYNC_STAGES)) u_sh_sync (
      .clk (clk),
      .rst (rst),
      .d   (sh_en[g]),
      .q   (sync_q)
    );

`ifdef FSM_SYNC_RFIN_SYNC_EN
    sync_chain #(.STAGES(SYNC_STAGES)) u_rf_sync (
      .clk (clk),
      .rst (rst),
      .d   (rfin[g]),
      .q   (rfin_eff)
    );
`else
    assign rfin_eff = rfin[g];
`endif

    assign fall = ~sync_q & sh_prev;

    // A saturated counter can no longer reach equality, so it also forces the exit.
    assign to_hit = (timeout_cycles != TIMEOUT_W'(TIMEOUT_DISABLE)) &&
                    ((cnt == timeout_cycles - TIMEOUT_W'(1)) || (&cnt));

    always_ff @(posedge clk) begin
      if (rst) begin
        st      <= ST_IDLE;
        cnt     <= '0;
        sh_prev <= 1'b0;
        done_q  <= 1'b0;
        err_q   <= 1'b0;
      end else begin
        sh_prev <= sync_q;
        done_q  <= 1'b0;
        if (err_clr[g]) err_q <= 1'b0;
        if (!ch_en[g]) begin
          st <= ST_IDLE;
        end else begin
          case (st)
            ST_IDLE: begin
              if (rfin_eff) begin
                st  <= ST_ACTIVE;
                cnt <= '0;
              end
            end
            ST_ACTIVE: begin
              if (fall) begin
                st     <= ST_IDLE;
                done_q <= 1'b1;
              end else if (to_hit) begin
                st    <= ST_IDLE;
                err_q <= 1'b1;
              end else if (~&cnt) begin
                cnt <= cnt + TIMEOUT_W'(1);
              end
            end
            default: st <= ST_IDLE;
          endcase
        end
      end
    end

    assign state[g]       = st;
    assign sh_en_sync[g]  = sync_q;
    assign done_pulse[g]  = done_q;
    assign timeout_err[g] = err_q;
  end

endmodule

// File: tb/tb_fsm_sync_multi.sv
// Self-checking bench for fsm_sync_multi (4 channels, 2-stage sync, 16-bit timeout).
module tb_fsm_sync_multi;

  localparam int unsigned NCH = 4;
  localparam int unsigned SS  = 2;
  localparam int unsigned TW  = 16;
`ifdef FSM_SYNC_RFIN_SYNC_EN
  localparam int unsigned EX  = SS;
`else
  localparam int unsigned EX  = 0;
`endif

  typedef struct {
    string      name;
    logic [11:0] v;   // {state, done_pulse, timeout_err}
  } exp_t;

  logic           clk;
  logic           rst;
  logic [NCH-1:0] ch_en, rfin, sh_en, err_clr;
  logic [TW-1:0]  timeout_cycles;
  logic [NCH-1:0] state, sh_en_sync, done_pulse, timeout_err;

  exp_t sb[$];
  exp_t ex;
  int   n_vec = 0;
  int   n_err = 0;

  fsm_sync_multi #(.NCH(NCH), .SYNC_STAGES(SS), .TIMEOUT_W(TW)) dut (
    .clk            (clk),
    .rst            (rst),
    .ch_en          (ch_en),
    .rfin           (rfin),
    .sh_en          (sh_en),
    .timeout_cycles (timeout_cycles),
    .err_clr        (err_clr),
    .state          (state),
    .sh_en_sync     (sh_en_sync),
    .done_pulse     (done_pulse),
    .timeout_err    (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse rfin for one edge; returns after the edge on which the channel enters ACTIVE.
  task automatic arm(input logic [NCH-1:0] m);
    rfin = rfin | m;
    tick();
    rfin = rfin & ~m;
    repeat (EX) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; ch_en = '1; rfin = '1; sh_en = '1; err_clr = '0; timeout_cycles = '0;
    repeat (3) tick();
    sb.push_back('{"reset_outputs", 12'h000});
    ex = sb.pop_front(); n_vec++;
    if ({state, done_pulse, timeout_err} !== ex.v) begin
      n_err++; $display("FAIL %s: got %h expected %h", ex.name, {state, done_pulse, timeout_err}, ex.v);
    end
    n_vec++;
    if (sh_en_sync !== 4'h0) begin
      n_err++; $display("FAIL reset_sync: got %h expected %h", sh_en_sync, 4'h0);
    end
    rst = 1'b0;
    sb.push_back('{"reset_release_arm", 12'hF00});
    repeat (1 + EX) tick();
    ex = sb.pop_front(); n_vec++;
    if ({state, done_pulse, timeout_err} !== ex.v) begin
      n_err++; $display("FAIL %s: got %h expected %h", ex.name, {state, done_pulse, timeout_err}, ex.v);
    end
    rfin = '0;
    repeat (2) tick();
  endtask

  task automatic test_normal_exit();
    sh_en = 4'b1110;
    tick();  // edge k
    n_vec++;
    if (sh_en_sync !== 4'hF) begin
      n_err++; $display("FAIL exit_sync_k: got %h expected %h", sh_en_sync, 4'hF);
    end
    tick();  // k+1
    n_vec++;
    if (sh_en_sync !== 4'hE) begin
      n_err++; $display("FAIL exit_sync_k1: got %h expected %h", sh_en_sync, 4'hE);
    end
    sb.push_back('{"exit_k1", 12'hF00});
    sb.push_back('{"exit_k2", 12'hE10});
    sb.push_back('{"exit_k3", 12'hE00});
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      ex = sb.pop_front(); n_vec++;
      if ({state, done_pulse, timeout_err} !== ex.v) begin
        n_err++; $display("FAIL %s: got %h expected %h", ex.name, {state, done_pulse, timeout_err}, ex.v);
      end
    end
    sh_en = '1;
    repeat (3) tick();
  endtask

  task automatic test_fall_idle();
    sh_en = 4'b1110;
    sb.push_back('{"fall_while_idle", 12'hE00});
    repeat (4) tick();
    ex = sb.pop_front(); n_vec++;
    if ({state, done_pulse, timeout_err} !== ex.v) begin
      n_err++; $display("FAIL %s: got %h expected %h", ex.name, {state, done_pulse, timeout_err}, ex.v);
    end
    sh_en = '1;
    repeat (3) tick();
  endtask

  task automatic test_back_to_back();
    rfin = 4'b0001;
    repeat (1 + EX) tick();
    n_vec++;
    if (state !== 4'hF) begin
      n_err++; $display("FAIL b2b_arm: got %h expected %h", state, 4'hF);
    end
    sh_en = 4'b1110;  // rfin[0] stays high across the exit
    tick();
    sb.push_back('{"b2b_k1", 12'hF00});
    sb.push_back('{"b2b_k2_exit", 12'hE10});
    sb.push_back('{"b2b_k3_rearm", 12'hF00});
    for (int i = 0; i < 3; i++) begin
      tick();
      ex = sb.pop_front(); n_vec++;
      if ({state, done_pulse, timeout_err} !== ex.v) begin
        n_err++; $display("FAIL %s: got %h expected %h", ex.name, {state, done_pulse, timeout_err}, ex.v);
      end
    end
    rfin = '0; sh_en = '1;
    repeat (3) tick();
  endtask

  task automatic test_timeout();
    ch_en = '0;
    sb.push_back('{"abort_all", 12'h000});
    tick();
    ex = sb.pop_front(); n_vec++;
    if ({state, done_pulse, timeout_err} !== ex.v) begin
      n_err++; $display("FAIL %s: got %h expected %h", ex.name, {state, done_pulse, timeout_err}, ex.v);
    end
    ch_en = '1; timeout_cycles = TW'(5);
    for (int pass = 0; pass < 2; pass++) begin
      arm(4'b0010);
      sb.push_back('{"to_entry", 12'h200});
      sb.push_back('{"to_edge4", 12'h200});
      sb.push_back('{"to_edge5_exit", 12'h002});
      for (int i = 0; i < 3; i++) begin
        if (i == 1) repeat (4) tick();
        if (i == 2) begin
          if (pass == 1) err_clr = 4'b0010;  // clear collides with the set
          tick();
          err_clr = '0;
        end
        ex = sb.pop_front(); n_vec++;
        if ({state, done_pulse, timeout_err} !== ex.v) begin
          n_err++; $display("FAIL %s: got %h expected %h", ex.name, {state, done_pulse, timeout_err}, ex.v);
        end
      end
      sb.push_back('{"to_sticky", 12'h002});
      sb.push_back('{"to_cleared", 12'h000});
      for (int i = 0; i < 2; i++) begin
        if (i == 1) err_clr = 4'b0010;
        tick();
        err_clr = '0;
        ex = sb.pop_front(); n_vec++;
        if ({state, done_pulse, timeout_err} !== ex.v) begin
          n_err++; $display("FAIL %s: got %h expected %h", ex.name, {state, done_pulse, timeout_err}, ex.v);
        end
      end
    end
  endtask

  task automatic test_fall_timeout();
    arm(4'b0100);
    repeat (2) tick();
    sh_en = 4'b1011;
    tick();
    sb.push_back('{"ft_before", 12'h400});
    sb.push_back('{"ft_fall_wins", 12'h040});
    for (int i = 0; i < 2; i++) begin
      tick();
      ex = sb.pop_front(); n_vec++;
      if ({state, done_pulse, timeout_err} !== ex.v) begin
        n_err++; $display("FAIL %s: got %h expected %h", ex.name, {state, done_pulse, timeout_err}, ex.v);
      end
    end
    sh_en = '1;
    repeat (3) tick();
  endtask

  task automatic test_abort_independence();
    timeout_cycles = '0;
    arm(4'hF);
    sb.push_back('{"ind_all_active", 12'hF00});
    sb.push_back('{"ind_abort_ch3", 12'h700});
    sb.push_back('{"ind_no_wrap", 12'h700});
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin ch_en = 4'b0111; tick(); end
      if (i == 2) repeat (70000) tick();
      ex = sb.pop_front(); n_vec++;
      if ({state, done_pulse, timeout_err} !== ex.v) begin
        n_err++; $display("FAIL %s: got %h expected %h", ex.name, {state, done_pulse, timeout_err}, ex.v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_normal_exit();
    test_fall_idle();
    test_back_to_back();
    test_timeout();
    test_fall_timeout();
    test_abort_independence();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
